// File: rtl/vector_lane_engine.sv
// rtl/vector_lane_engine.sv - multi-lane vector ALU engine, LANES elements per beat
module vector_lane_engine #(
  parameter int L     = 8,
  parameter int V     = 20,
  parameter int LANES = 4
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start_i,
  input  logic           flush_i,
  input  logic           mode_i,
  input  logic [1:0]     alu_ctrl_i,
  input  logic [V*L-1:0] vec_a_i,
  input  logic [V*L-1:0] vec_b_i,
  input  logic [L-1:0]   scalar_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [V*L-1:0] result_o,
  output logic           zero_o
);

  localparam int NBEATS = (V + LANES - 1) / LANES;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [V*L-1:0] a_q, a_d;
  logic [V*L-1:0] b_q, b_d;
  logic [L-1:0]   scalar_q, scalar_d;
  logic           mode_q, mode_d;
  logic [1:0]     ctrl_q, ctrl_d;
  logic [V*L-1:0] result_q, result_d;
  logic           zero_q, zero_d;
  logic           last_beat;

  assign last_beat = (beat_q == BW'(NBEATS - 1));

  function automatic logic [L-1:0] alu(input logic [1:0] ctrl,
                                       input logic [L-1:0] x,
                                       input logic [L-1:0] y);
    logic [L-1:0] r;
    case (ctrl)
      2'b00:   r = x + y;
      2'b01:   r = x - y;
      2'b10:   r = x & y;
      default: r = x | y;
    endcase
    return r;
  endfunction

  // State register; reset overrides everything.
  always_ff @(posedge CLK) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next state: flush wins over progress; DONE always lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN: begin
        if (flush_i)        state_d = S_IDLE;
        else if (last_beat) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    busy_o = (state_q != S_IDLE);
    done_o = (state_q == S_DONE);
  end

  // Datapath next-state: operand capture on accept, lane writes per beat.
  always_comb begin
    int idx;
    logic [L-1:0] op_a;
    logic [L-1:0] op_b;
    beat_d   = beat_q;
    a_d      = a_q;
    b_d      = b_q;
    scalar_d = scalar_q;
    mode_d   = mode_q;
    ctrl_d   = ctrl_q;
    result_d = result_q;
    zero_d   = 1'b0;
    idx      = 0;
    op_a     = '0;
    op_b     = '0;
    if (state_q == S_IDLE && start_i) begin
      a_d      = vec_a_i;
      b_d      = vec_b_i;
      scalar_d = scalar_i;
      mode_d   = mode_i;
      ctrl_d   = alu_ctrl_i;
      beat_d   = '0;
    end else if (state_q == S_RUN && !flush_i) begin
      for (int k = 0; k < LANES; k++) begin
        idx = int'(beat_q) * LANES + k;
        // Lanes past the end of the vector on a partial last beat stay idle.
        if (idx < V) begin
          op_a = a_q[idx*L +: L];
          op_b = mode_q ? scalar_q : b_q[idx*L +: L];
          result_d[idx*L +: L] = alu(ctrl_q, op_a, op_b);
        end
      end
      beat_d = beat_q + 1'b1;
      if (last_beat) zero_d = (result_d == '0);
    end
  end

  // Datapath registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      beat_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      scalar_q <= '0;
      mode_q   <= 1'b0;
      ctrl_q   <= 2'b00;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      beat_q   <= beat_d;
      a_q      <= a_d;
      b_q      <= b_d;
      scalar_q <= scalar_d;
      mode_q   <= mode_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign result_o = result_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_vector_lane_engine.sv
// tb/tb_vector_lane_engine.sv - self-checking bench for vector_lane_engine (LANES=4 and LANES=3)
module tb_vector_lane_engine;

  localparam int L = 8;
  localparam int V = 20;

  logic           CLK = 1'b0;
  logic           RST;
  logic           start_i, flush_i, mode_i;
  logic [1:0]     alu_ctrl_i;
  logic [V*L-1:0] vec_a_i, vec_b_i;
  logic [L-1:0]   scalar_i;
  logic           busy4, done4, zero4, busy3, done3, zero3;
  logic [V*L-1:0] res4, res3;

  vector_lane_engine #(.L(L), .V(V), .LANES(4)) dut4 (
    .CLK(CLK), .RST(RST), .start_i(start_i), .flush_i(flush_i), .mode_i(mode_i),
    .alu_ctrl_i(alu_ctrl_i), .vec_a_i(vec_a_i), .vec_b_i(vec_b_i), .scalar_i(scalar_i),
    .busy_o(busy4), .done_o(done4), .result_o(res4), .zero_o(zero4));

  vector_lane_engine #(.L(L), .V(V), .LANES(3)) dut3 (
    .CLK(CLK), .RST(RST), .start_i(start_i), .flush_i(flush_i), .mode_i(mode_i),
    .alu_ctrl_i(alu_ctrl_i), .vec_a_i(vec_a_i), .vec_b_i(vec_b_i), .scalar_i(scalar_i),
    .busy_o(busy3), .done_o(done3), .result_o(res3), .zero_o(zero3));

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int a[V];
  int b[V];
  int sc, md, op;
  int fresh[V];
  int exp4[V];
  int exp3[V];

  task automatic chk(input string tag, input logic [V*L-1:0] obs, input logic [V*L-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: one element of the operation, plain modulo-256 arithmetic.
  function automatic int model_elem(input int i);
    int y;
    y = (md != 0) ? sc : b[i];
    case (op)
      0:       return (a[i] + y) % 256;
      1:       return (a[i] - y + 256) % 256;
      2:       return a[i] & y;
      default: return a[i] | y;
    endcase
  endfunction

  function automatic logic [V*L-1:0] pack(input int e[V]);
    logic [V*L-1:0] r;
    for (int i = 0; i < V; i++) r[i*L +: L] = 8'(e[i]);
    return r;
  endfunction

  function automatic logic all_zero(input int e[V]);
    for (int i = 0; i < V; i++) if (e[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [V*L-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive operands and pulse start for one accept edge, then scramble the inputs.
  task automatic start_op(input logic with_flush);
    @(negedge CLK);
    for (int i = 0; i < V; i++) begin
      vec_a_i[i*L +: L] = 8'(a[i]);
      vec_b_i[i*L +: L] = 8'(b[i]);
      fresh[i] = model_elem(i);
    end
    scalar_i   = 8'(sc);
    mode_i     = md[0];
    alu_ctrl_i = 2'(op);
    start_i    = 1'b1;
    flush_i    = with_flush;
    @(negedge CLK);
    start_i    = 1'b0;
    flush_i    = 1'b0;
    vec_a_i    = rnd_vec();
    vec_b_i    = rnd_vec();
    scalar_i   = 8'($urandom);
    mode_i     = 1'($urandom);
    alu_ctrl_i = 2'($urandom);
  endtask

  // Full operation on both instances; checks latency, pulse width, result and zero flag.
  task automatic run_op(input string tag);
    int d4, d3, p4, p3;
    logic zexp;
    start_op(1'b0);
    for (int i = 0; i < V; i++) begin
      exp4[i] = fresh[i];
      exp3[i] = fresh[i];
    end
    zexp = all_zero(fresh);
    d4 = 0; d3 = 0; p4 = 0; p3 = 0;
    for (int n = 1; n <= 12; n++) begin
      start_i = (n <= 3);
      @(negedge CLK);
      if (n == 1) begin
        chk({tag, " busy"}, (V*L)'({busy4, busy3}), (V*L)'(2'b11));
        chk({tag, " zero_idle"}, (V*L)'({zero4, zero3}), '0);
      end
      if (done4) begin
        p4++;
        if (d4 == 0) begin
          d4 = n;
          chk({tag, " res4"}, res4, pack(exp4));
          chk({tag, " zero4"}, (V*L)'(zero4), (V*L)'(zexp));
        end
      end
      if (done3) begin
        p3++;
        if (d3 == 0) begin
          d3 = n;
          chk({tag, " res3"}, res3, pack(exp3));
          chk({tag, " zero3"}, (V*L)'(zero3), (V*L)'(zexp));
        end
      end
    end
    start_i = 1'b0;
    chk({tag, " lat4"}, (V*L)'(d4), (V*L)'(5));
    chk({tag, " lat3"}, (V*L)'(d3), (V*L)'(7));
    chk({tag, " pulses"}, (V*L)'({p4[7:0], p3[7:0]}), (V*L)'(16'h0101));
    chk({tag, " hold4"}, res4, pack(exp4));
    chk({tag, " hold3"}, res3, pack(exp3));
    chk({tag, " idle"}, (V*L)'({busy4, busy3, zero4, zero3}), '0);
  endtask

  initial begin
    RST = 1'b0; start_i = 1'b0; flush_i = 1'b0; mode_i = 1'b0; alu_ctrl_i = 2'b00;
    vec_a_i = '0; vec_b_i = '0; scalar_i = '0;
    for (int i = 0; i < V; i++) begin exp4[i] = 0; exp3[i] = 0; end
    repeat (2) @(negedge CLK);
    chk("reset outputs", (V*L)'({busy4, done4, zero4, busy3, done3, zero3}), '0);
    chk("reset res4", res4, '0);
    chk("reset res3", res3, '0);
    RST = 1'b1;

    // VV ADD a=i, b=2i
    md = 0; op = 0; sc = 0;
    for (int i = 0; i < V; i++) begin a[i] = i; b[i] = 2 * i; end
    run_op("vv_add_ramp");

    // VV ADD with wrap in element 0
    for (int i = 0; i < V; i++) begin a[i] = int'($urandom_range(255)); b[i] = int'($urandom_range(255)); end
    a[0] = 200; b[0] = 100;
    run_op("vv_add_wrap");
    chk("wrap elem0", (V*L)'(res4[7:0]), (V*L)'(44));

    // VS SUB scalar=5, a=i
    md = 1; op = 1; sc = 5;
    for (int i = 0; i < V; i++) begin a[i] = i; b[i] = int'($urandom_range(255)); end
    run_op("vs_sub");
    chk("vs_sub ends", (V*L)'({res4[7:0], res4[19*L +: L]}), (V*L)'({8'd251, 8'd14}));

    // Random operations
    for (int t = 0; t < 6; t++) begin
      md = int'($urandom_range(1)); op = int'($urandom_range(3)); sc = int'($urandom_range(255));
      for (int i = 0; i < V; i++) begin a[i] = int'($urandom_range(255)); b[i] = int'($urandom_range(255)); end
      run_op($sformatf("rand%0d", t));
    end

    // AND with zero operand B, vector and scalar forms
    md = 0; op = 2; sc = 77;
    for (int i = 0; i < V; i++) begin a[i] = int'($urandom_range(1, 255)); b[i] = 0; end
    run_op("vv_and_zero");
    md = 1; sc = 0;
    for (int i = 0; i < V; i++) b[i] = int'($urandom_range(255));
    run_op("vs_and_zero");

    // Flush after two beats; flush also held high on the accept cycle (IDLE, no effect)
    md = 0; op = 3; sc = 0;
    for (int i = 0; i < V; i++) begin a[i] = int'($urandom_range(255)); b[i] = int'($urandom_range(1, 255)); end
    start_op(1'b1);
    begin
      int pd;
      pd = 0;
      start_i = 1'b1;
      @(negedge CLK);
      if (done4 || done3) pd++;
      @(negedge CLK);
      if (done4 || done3) pd++;
      chk("flush busy before", (V*L)'({busy4, busy3}), (V*L)'(2'b11));
      flush_i = 1'b1;
      @(negedge CLK);
      flush_i = 1'b0;
      start_i = 1'b0;
      for (int i = 0; i < 8; i++) exp4[i] = fresh[i];
      for (int i = 0; i < 6; i++) exp3[i] = fresh[i];
      chk("flush busy after", (V*L)'({busy4, busy3, done4, done3}), '0);
      chk("flush res4", res4, pack(exp4));
      chk("flush res3", res3, pack(exp3));
      repeat (8) begin
        @(negedge CLK);
        if (done4 || done3) pd++;
      end
      chk("flush no done", (V*L)'(pd), '0);
    end
    md = 1; op = 0; sc = int'($urandom_range(255));
    run_op("after_flush");

    // Reset held for two cycles in the middle of a run
    md = 0; op = 1;
    for (int i = 0; i < V; i++) begin a[i] = int'($urandom_range(255)); b[i] = int'($urandom_range(255)); end
    start_op(1'b0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("midrun reset outputs", (V*L)'({busy4, done4, zero4, busy3, done3, zero3}), '0);
    chk("midrun reset res4", res4, '0);
    chk("midrun reset res3", res3, '0);
    RST = 1'b1;
    for (int i = 0; i < V; i++) begin exp4[i] = 0; exp3[i] = 0; end
    run_op("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
